// File: rtl/inst_mem_pipe_if.sv
// Fetch/response and loader bundle between the IF stage and inst_mem_pipe.
// Latency: none; this file holds wires only.
// Backpressure: valid/ready on both the request and the response sides. The loader has no ready.
//
// master: IF stage / loader side
//   drives im_req_valid, im_addr, im_flush, im_rsp_ready, ld_we, ld_addr, ld_data
// slave: instruction memory side
//   drives im_req_ready, im_rsp_valid, im_inst, im_fault
interface inst_mem_pipe_if;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_addr;
  logic        im_flush;
  logic        im_rsp_valid;
  logic        im_rsp_ready;
  logic [31:0] im_inst;
  logic        im_fault;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output im_req_valid, im_addr, im_flush, im_rsp_ready, ld_we, ld_addr, ld_data,
    input  im_req_ready, im_rsp_valid, im_inst, im_fault
  );

  modport slave (
    input  im_req_valid, im_addr, im_flush, im_rsp_ready, ld_we, ld_addr, ld_data,
    output im_req_ready, im_rsp_valid, im_inst, im_fault
  );
endinterface

// File: rtl/inst_mem_pipe.sv
// Synchronous-read instruction memory for the RV32I IF stage, with a run-time loader port.
// Latency: the response is valid LATENCY cycles after the accept cycle (1..4).
// Backpressure: the response is held until im_rsp_ready. im_req_ready is low while a fetch is outstanding.
//
// Ports: clk, rst_n (async active-low); bus = inst_mem_pipe_if.slave
//   (fetch request/response handshake, flush, loader write port).
// Optional feature macro: INST_MEM_FAULT_EN. When it is defined, misaligned or
// out-of-range fetches return NOP with im_fault=1, and such loader writes are dropped.
// When it is not defined, im_fault is 0 and addresses wrap modulo DEPTH.
module inst_mem_pipe #(
  parameter  int DEPTH   = 512,
  parameter  int LATENCY = 1,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  inst_mem_pipe_if.slave bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              req_ready;
  logic              accept;
  logic              promote;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_fault;
  logic              wr_ok;
  logic [31:0]       rd_word;

  logic [31:0]       hold_inst_q;
  logic              hold_fault_q;
  logic [31:0]       inst_q;
  logic              fault_q;

  assign rd_idx = bus.im_addr[IDX_W+1:2];
  assign wr_idx = bus.ld_addr[IDX_W+1:2];

`ifdef INST_MEM_FAULT_EN
  assign rd_fault = (bus.im_addr[1:0] != 2'b00) || (bus.im_addr[31:IDX_W+2] != '0);
  assign wr_ok    = (bus.ld_addr[1:0] == 2'b00) && (bus.ld_addr[31:IDX_W+2] == '0);
`else
  // Without fault checking, the low bits and the bits above the index are ignored.
  // As a result, addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.im_addr[1:0], bus.im_addr[31:IDX_W+2],
                              bus.ld_addr[1:0], bus.ld_addr[31:IDX_W+2]};
  assign rd_fault = 1'b0;
  assign wr_ok    = 1'b1;
`endif

  // A faulting fetch never exposes memory contents.
  assign rd_word = rd_fault ? NOP : mem[rd_idx];

  // Next-state logic. Flush overrides everything, including a handshake in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    promote   = 1'b0;
    req_ready = !bus.im_flush &&
                (state_q == IDLE || (state_q == RESP && bus.im_rsp_ready));
    accept    = bus.im_req_valid && req_ready;

    if (bus.im_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        // The counter is loaded with LATENCY-1. The response goes valid on the edge
        // where the counter reaches zero, which is LATENCY-1 edges after the accept edge.
        WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_d = RESP;
            cnt_d   = '0;
            promote = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        RESP: if (bus.im_rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      // An accept here also covers the back-to-back case, where the handshake and
      // the next accept happen in the same RESP cycle.
      if (accept) begin
        if (LATENCY == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(LATENCY - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The read happens at the accept edge. The result is held in hold_* while waiting.
  // The visible response only changes when the response becomes valid, so im_inst
  // keeps its last value at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_inst_q  <= NOP;
      hold_fault_q <= 1'b0;
      inst_q       <= NOP;
      fault_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_inst_q  <= rd_word;
        hold_fault_q <= rd_fault;
      end
      if (accept && LATENCY == 1) begin
        inst_q  <= rd_word;
        fault_q <= rd_fault;
      end else if (promote) begin
        inst_q  <= hold_inst_q;
        fault_q <= hold_fault_q;
      end
    end
  end

  // Loader write port. The storage is never reset. A write on the same edge as an
  // accept to the same word returns the old data, because the read above samples
  // the array before this update lands.
  always_ff @(posedge clk) begin
    if (bus.ld_we && wr_ok) begin
      mem[wr_idx] <= bus.ld_data;
    end
  end

  assign bus.im_req_ready = req_ready;
  assign bus.im_rsp_valid = (state_q == RESP);
  assign bus.im_inst      = inst_q;
  assign bus.im_fault     = fault_q;

endmodule

// File: tb/tb_inst_mem_pipe.sv
module tb_inst_mem_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_mem_pipe_if if0 ();
  inst_mem_pipe_if if1 ();

  inst_mem_pipe #(.DEPTH(512), .LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  inst_mem_pipe #(.DEPTH(512), .LATENCY(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Per-instance stimulus: index 0 is LATENCY=1, index 1 is LATENCY=3.
  logic        req_valid [2];
  logic        flush     [2];
  logic        rsp_ready [2];
  logic        ld_we     [2];
  logic [31:0] addr      [2];
  logic [31:0] ld_addr   [2];
  logic [31:0] ld_data   [2];
  logic        o_rdy     [2];
  logic        o_vld     [2];
  logic        o_flt     [2];
  logic [31:0] o_inst    [2];

  assign if0.im_req_valid = req_valid[0];
  assign if0.im_addr      = addr[0];
  assign if0.im_flush     = flush[0];
  assign if0.im_rsp_ready = rsp_ready[0];
  assign if0.ld_we        = ld_we[0];
  assign if0.ld_addr      = ld_addr[0];
  assign if0.ld_data      = ld_data[0];
  assign o_rdy[0]  = if0.im_req_ready;
  assign o_vld[0]  = if0.im_rsp_valid;
  assign o_flt[0]  = if0.im_fault;
  assign o_inst[0] = if0.im_inst;

  assign if1.im_req_valid = req_valid[1];
  assign if1.im_addr      = addr[1];
  assign if1.im_flush     = flush[1];
  assign if1.im_rsp_ready = rsp_ready[1];
  assign if1.ld_we        = ld_we[1];
  assign if1.ld_addr      = ld_addr[1];
  assign if1.ld_data      = ld_data[1];
  assign o_rdy[1]  = if1.im_req_ready;
  assign o_vld[1]  = if1.im_rsp_valid;
  assign o_flt[1]  = if1.im_fault;
  assign o_inst[1] = if1.im_inst;

  // ---------------- behavioural model ----------------
  logic [31:0] mm [2][512];
  logic        m_busy [2];
  logic        m_vld  [2];
  logic        m_flt  [2];
  logic        p_flt  [2];
  logic [31:0] m_inst [2];
  logic [31:0] p_inst [2];
  int          m_rem  [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef INST_MEM_FAULT_EN
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd512);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rd_model(input int k, input logic [31:0] a);
    return bad_addr(a) ? NOP : mm[k][a[10:2]];
  endfunction

  // The block is free when nothing is outstanding, or when the response is being consumed.
  function automatic logic exp_ready(input int k);
    return !flush[k] && !m_busy[k] && (!m_vld[k] || rsp_ready[k]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0;
        m_vld[k]  <= 1'b0;
        m_flt[k]  <= 1'b0;
        m_inst[k] <= NOP;
        m_rem[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush[k]) begin
          m_busy[k] <= 1'b0;
          m_vld[k]  <= 1'b0;
        end else if (req_valid[k] && exp_ready(k)) begin
          if (lat_of(k) == 1) begin
            m_vld[k]  <= 1'b1;
            m_inst[k] <= rd_model(k, addr[k]);
            m_flt[k]  <= bad_addr(addr[k]);
          end else begin
            m_vld[k]  <= 1'b0;
            m_busy[k] <= 1'b1;
            m_rem[k]  <= lat_of(k) - 1;
            p_inst[k] <= rd_model(k, addr[k]);
            p_flt[k]  <= bad_addr(addr[k]);
          end
        end else if (m_busy[k]) begin
          if (m_rem[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_vld[k]  <= 1'b1;
            m_inst[k] <= p_inst[k];
            m_flt[k]  <= p_flt[k];
          end else begin
            m_rem[k] <= m_rem[k] - 1;
          end
        end else if (m_vld[k] && rsp_ready[k]) begin
          m_vld[k] <= 1'b0;
        end
        if (ld_we[k] && !bad_addr(ld_addr[k])) mm[k][ld_addr[k][10:2]] <= ld_data[k];
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_rsp_valid%0d", k), 32'(o_vld[k]), 32'(m_vld[k]));
      chk($sformatf("model_req_ready%0d", k), 32'(o_rdy[k]), 32'(exp_ready(k)));
      chk($sformatf("model_inst%0d", k), o_inst[k], m_inst[k]);
      if (m_vld[k]) chk($sformatf("model_fault%0d", k), 32'(o_flt[k]), 32'(m_flt[k]));
    end
  endtask

  // Compare on the falling edge, then return to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) cmp_all();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    ld_we[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
    tick();
    ld_we[k] = 1'b0;
  endtask

  // Present a request and hold it until the accept edge has passed.
  task automatic fetch(input int k, input logic [31:0] a);
    req_valid[k] = 1'b1; addr[k] = a;
    tick();
    req_valid[k] = 1'b0;
  endtask

  int n;

  initial begin
    rst_n  = 1'b0;
    chk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; flush[k] = 1'b0; rsp_ready[k] = 1'b0; ld_we[k] = 1'b0;
      addr[k] = '0; ld_addr[k] = '0; ld_data[k] = '0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_valid%0d", k), 32'(o_vld[k]), 32'd0);
      chk($sformatf("reset_inst%0d", k), o_inst[k], NOP);
      chk($sformatf("reset_fault%0d", k), 32'(o_flt[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    load(0, 32'd0,  32'h0a80_0093);
    load(0, 32'd4,  32'h0010_2023);
    load(0, 32'd20, 32'h00a0_0513);
    load(1, 32'd8,  32'h0000_2c03);
    load(1, 32'd12, 32'h0140_0693);
    load(1, 32'd16, 32'h00c0_0613);

    // Back-to-back fetches at LATENCY=1.
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; addr[0] = 32'd0;
    tick();
    chk("b2b_vld0", 32'(o_vld[0]), 32'd1);
    chk("b2b_inst0", o_inst[0], 32'h0a80_0093);
    chk("b2b_rdy0", 32'(o_rdy[0]), 32'd1);
    addr[0] = 32'd4;
    tick();
    req_valid[0] = 1'b0;
    chk("b2b_vld1", 32'(o_vld[0]), 32'd1);
    chk("b2b_inst1", o_inst[0], 32'h0010_2023);
    tick();
    chk("b2b_idle", 32'(o_vld[0]), 32'd0);
    chk("b2b_inst_kept", o_inst[0], 32'h0010_2023);

    // LATENCY=3 timing, then the response is held under backpressure.
    rsp_ready[1] = 1'b0;
    fetch(1, 32'd8);
    chk("lat3_c1", 32'(o_vld[1]), 32'd0);
    tick();
    chk("lat3_c2", 32'(o_vld[1]), 32'd0);
    tick();
    chk("lat3_c3_vld", 32'(o_vld[1]), 32'd1);
    chk("lat3_c3_inst", o_inst[1], 32'h0000_2c03);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_inst", o_inst[1], 32'h0000_2c03);
      chk("hold_vld", 32'(o_vld[1]), 32'd1);
      chk("hold_rdy", 32'(o_rdy[1]), 32'd0);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    tick();
    chk("hold_release", 32'(o_vld[1]), 32'd0);

    // Flush one cycle after the accept. No response may appear.
    fetch(1, 32'd12);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_rsp", 32'(o_vld[1]), 32'd0);
    end
    fetch(1, 32'd16);
    n = 0;
    while (!o_vld[1] && n < 10) begin
      tick();
      n++;
    end
    chk("flush_next_vld", 32'(o_vld[1]), 32'd1);
    chk("flush_next_inst", o_inst[1], 32'h00c0_0613);
    chk("flush_next_lat", 32'(n), 32'd2);
    tick();

    // Loader write on the same edge as the accept returns the old data.
    req_valid[0] = 1'b1; addr[0] = 32'd20;
    ld_we[0] = 1'b1; ld_addr[0] = 32'd20; ld_data[0] = 32'hdead_beef;
    tick();
    req_valid[0] = 1'b0; ld_we[0] = 1'b0;
    chk("collide_old", o_inst[0], 32'h00a0_0513);
    tick();
    fetch(0, 32'd20);
    chk("collide_new", o_inst[0], 32'hdead_beef);
    tick();

    // Wrapped or faulting addresses.
    fetch(0, 32'h800);
    chk("wrap_vld", 32'(o_vld[0]), 32'd1);
`ifdef INST_MEM_FAULT_EN
    chk("oor_fault", 32'(o_flt[0]), 32'd1);
    chk("oor_inst", o_inst[0], NOP);
`else
    chk("wrap_fault", 32'(o_flt[0]), 32'd0);
    chk("wrap_inst", o_inst[0], 32'h0a80_0093);
`endif
    tick();
    fetch(0, 32'h2);
`ifdef INST_MEM_FAULT_EN
    chk("misalign_fault", 32'(o_flt[0]), 32'd1);
    chk("misalign_inst", o_inst[0], NOP);
`else
    chk("lowbits_inst", o_inst[0], 32'h0a80_0093);
`endif
    tick();

    // Asynchronous reset while a fetch is in WAIT.
    rsp_ready[1] = 1'b0;
    fetch(1, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(o_vld[1]), 32'd0);
    chk("arst_inst", o_inst[1], NOP);
    chk("arst_idle_rdy", 32'(o_rdy[1]), 32'd1);
    chk("arst_inst_other", o_inst[0], NOP);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_lost", 32'(o_vld[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    fetch(1, 32'd8);
    tick();
    tick();
    chk("retained1", o_inst[1], 32'h0000_2c03);
    fetch(0, 32'd4);
    chk("retained0", o_inst[0], 32'h0010_2023);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
